exec_hazard_sequencer: RTL and testbench
========================================

Name: exec_hazard_sequencer

Overview:
- Controls the execute stage: drives forwarding selects into the E-stage operand muxes (ForwardAE/ForwardBE) and generates pipeline stall/flush controls.
- Handles load-use hazards and taken branches/jumps (PCSrcE).
- Sequences an external iterative mul/div unit: issues a start pulse, holds F/D/E, and bubbles M until the unit reports done.
- Sits beside the 5-stage pipeline and owns every Stall*/Flush* enable.

Parameters:
- MD_TIMEOUT, 64: max BUSY cycles before forced abort; legal range 2..255.
- LOAD_SRC, 2'b01: ResultSrcE encoding that identifies a load in E.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- Rs1D, Rs2D  in  5 each  source regs in Decode
- Rs1E, Rs2E  in  5 each  source regs in Execute
- RdE, RdM, RdW  in  5 each  destination regs per stage
- RegWriteM, RegWriteW  in  1 each  write-enables in M/W
- ResultSrcE  in  2  result select of E instruction
- PCSrcE  in  1  taken branch/jump resolved in E
- MulDivE  in  1  E holds a mul/div instruction
- MdDone  in  1  iterative unit result valid (single-cycle pulse)
- ForwardAE, ForwardBE  out  2 each  00 register file, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE  out  1 each  hold pipeline registers
- FlushD, FlushE, FlushM  out  1 each  insert bubble into D/E/M registers
- MdStart  out  1  one-cycle start pulse; unit latches operands on this cycle
- MdErr  out  1  sticky timeout flag; cleared only by rst

Behaviour:
- Reset (rst=1 at posedge): FSM=IDLE, counter=0, MdErr=0.
  - MdStart=0 during reset.
  - Comb outputs follow the rules below with FSM=IDLE.
- Forwarding (combinational), per operand, shown for A:
  - 10 if RegWriteM & RdM!=0 & Rs1E==RdM.
  - Else 01 if RegWriteW & RdW!=0 & Rs1E==RdW.
  - Else 00.
  - M has priority over W. x0 never forwards.
- lwStall = (ResultSrcE==LOAD_SRC) & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when MulDivE & !PCSrcE. MdStart=1 for exactly that cycle; counter cleared.
  - BUSY -> DONE on MdDone=1, or when counter==MD_TIMEOUT-1 (sets MdErr).
  - BUSY with neither condition: counter increments, saturating 8-bit.
  - DONE -> IDLE unconditionally.
  - In DONE, the E/M register captures the result; no stalls come from the FSM.
- Output priority, highest first:
  1. FSM in IDLE with MdStart high, or in BUSY: StallF=StallD=StallE=1, FlushM=1, FlushD=FlushE=0. lwStall and PCSrcE are ignored.
  2. PCSrcE=1: FlushD=FlushE=1, no stalls.
  3. lwStall: StallF=StallD=1, FlushE=1.
  4. Otherwise all stall/flush outputs 0.
- Latency and ordering:
  - A mul/div occupies E for N+2 cycles, where N is the number of BUSY cycles: start cycle, then BUSY, then DONE.
  - MdDone arriving in the same cycle as MdStart is ignored; the unit needs at least one cycle.
  - MdDone arriving in IDLE or DONE is ignored.
- Reset mid-operation: FSM returns to IDLE immediately and all stalls drop the next cycle. The iterative unit is reset by the same rst.
- PCSrcE and MulDivE both high: cannot both be legal in E. Branch wins and no start is issued.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs PerfStallCnt[31:0] and PerfFlushCnt[31:0].
  - PerfStallCnt increments each cycle StallF=1.
  - PerfFlushCnt increments each cycle FlushE=1 or FlushM=1.
  - Both wrap at 2^32 and clear on rst.
- Undefined: ports and counters absent; remaining behaviour identical.

Test Plan:
1. Forwarding: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01. Then RdW=0 -> ForwardAE=00.
2. Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. Same with RdE=0 -> no stall.
3. Branch with pending load-use: PCSrcE=1 and lwStall true -> FlushD=FlushE=1, StallF=StallD=0.
4. Mul/div: MulDivE=1 at cycle 0 -> MdStart=1 at cycle 0 only. MdDone pulses at cycle 4. Required:
   - Stalls and FlushM high for cycles 0-4.
   - DONE at cycle 5 with all stalls low; IDLE at cycle 6.
5. Timeout: MD_TIMEOUT=4, MdDone never asserted -> BUSY 4 cycles, then DONE, MdErr=1 and held until rst.
6. rst asserted during BUSY cycle 2 -> next cycle FSM=IDLE, all stall/flush outputs 0, MdErr=0. With HAZARD_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/exec_hazard_sequencer.sv
// Execute-stage hazard control: operand forwarding, load-use/branch stall-flush, iterative mul/div sequencing.
// Optional HAZARD_PERF_EN adds free-running stall/flush performance counters.
module exec_hazard_sequencer #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter logic [1:0]  LOAD_SRC   = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MulDivE,
  input  logic       MdDone,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MdStart,
  output logic       MdErr
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] PerfStallCnt,
  output logic [31:0] PerfFlushCnt
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  localparam logic [7:0] TO_LAST = 8'(MD_TIMEOUT - 1);

  md_state_t  state_q;
  logic [7:0] cnt_q;
  logic       err_q;
  logic       lw_stall;
  logic       md_hold;

  // M-stage result is younger than W, so it wins; x0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                         input logic ww, input logic [4:0] rdw);
    if (wm && rdm != 5'd0 && rs == rdm)      return 2'b10;
    else if (ww && rdw != 5'd0 && rs == rdw) return 2'b01;
    else                                     return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  assign lw_stall = (ResultSrcE == LOAD_SRC) && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));

  // Start is issued from IDLE in the same cycle the instruction sits in E; a taken branch squashes it.
  assign MdStart = (state_q == IDLE) && MulDivE && !PCSrcE && !rst;
  assign md_hold = MdStart || (state_q == BUSY);
  assign MdErr   = err_q;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (md_hold) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (MdStart) begin
          state_q <= BUSY;
          cnt_q   <= 8'd0;
        end
        BUSY: begin
          // A real completion takes precedence over a coincident timeout.
          if (MdDone) begin
            state_q <= DONE;
          end else if (cnt_q == TO_LAST) begin
            state_q <= DONE;
            err_q   <= 1'b1;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (StallF)           perf_stall_q <= perf_stall_q + 32'd1;
      if (FlushE || FlushM) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign PerfStallCnt = perf_stall_q;
  assign PerfFlushCnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_exec_hazard_sequencer.sv
// Directed plus randomized checking of exec_hazard_sequencer against a cycle-level behavioural model.
module tb_exec_hazard_sequencer;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, PCSrcE, MulDivE, MdDone;
  logic [1:0] ResultSrcE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MdStart, MdErr;
`ifdef HAZARD_PERF_EN
  logic [31:0] PerfStallCnt, PerfFlushCnt;
`endif

  exec_hazard_sequencer #(.MD_TIMEOUT(TO), .LOAD_SRC(2'b01)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulDivE(MulDivE), .MdDone(MdDone),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MdStart(MdStart), .MdErr(MdErr)
`ifdef HAZARD_PERF_EN
    , .PerfStallCnt(PerfStallCnt), .PerfFlushCnt(PerfFlushCnt)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Model: is a mul/div in flight, how many busy cycles elapsed, is the result-capture cycle pending
  bit in_flight = 0;
  bit capture   = 0;
  int busy_n    = 0;
  bit err_m     = 0;
  longint stall_tot = 0;
  longint flush_tot = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && rs == RdM) return 2'b10;
    if (RegWriteW && RdW != 0 && rs == RdW) return 2'b01;
    return 2'b00;
  endfunction

  // Check this cycle's outputs, then advance the model across the clock edge.
  task automatic cyc();
    bit start, hold, lw;
    bit [5:0] exp_sf;
    #2;
    start = !in_flight && !capture && MulDivE && !PCSrcE && !rst;
    hold  = start || in_flight;
    lw    = ResultSrcE == 2'b01 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
    if (hold)        exp_sf = 6'b111_001;
    else if (PCSrcE) exp_sf = 6'b000_110;
    else if (lw)     exp_sf = 6'b110_010;
    else             exp_sf = 6'b000_000;
    chk("ForwardAE", 32'(ForwardAE), 32'(m_fwd(Rs1E)));
    chk("ForwardBE", 32'(ForwardBE), 32'(m_fwd(Rs2E)));
    chk("stall_flush{F,D,E,fD,fE,fM}", 32'({StallF, StallD, StallE, FlushD, FlushE, FlushM}), 32'(exp_sf));
    chk("MdStart", 32'(MdStart), 32'(start));
    chk("MdErr", 32'(MdErr), 32'(err_m));
`ifdef HAZARD_PERF_EN
    chk("PerfStallCnt", PerfStallCnt, 32'(stall_tot));
    chk("PerfFlushCnt", PerfFlushCnt, 32'(flush_tot));
`endif
    @(posedge clk);
    if (rst) begin
      in_flight = 0; capture = 0; busy_n = 0; err_m = 0; stall_tot = 0; flush_tot = 0;
    end else begin
      stall_tot = (stall_tot + exp_sf[5]) % 64'h1_0000_0000;
      flush_tot = (flush_tot + (exp_sf[1] | exp_sf[0])) % 64'h1_0000_0000;
      if (capture) capture = 0;
      else if (in_flight) begin
        busy_n++;
        if (MdDone) begin in_flight = 0; capture = 1; end
        else if (busy_n == TO) begin in_flight = 0; capture = 1; err_m = 1; end
      end else if (start) begin
        in_flight = 1; busy_n = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, PCSrcE, MulDivE, MdDone} = '0;
    ResultSrcE = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    cyc();
    rst = 1'b0;
    cyc();

    // Forwarding priority and x0 suppression
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
    cyc();
    RegWriteM = 0; cyc();
    RdW = 0; cyc();
    idle_inputs();

    // Load-use, then the same with RdE=x0
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; cyc();
    ResultSrcE = 2'b00; cyc();
    ResultSrcE = 2'b01; RdE = 0; cyc();
    // Branch overrides a pending load-use
    RdE = 7; PCSrcE = 1; cyc();
    idle_inputs();

    // Mul/div completing on the fourth busy cycle
    MulDivE = 1;
    for (int c = 0; c < 7; c++) begin
      MdDone = (c == 4);
      if (c == 6) MulDivE = 0;
      cyc();
    end
    idle_inputs();

    // Timeout: never done
    MulDivE = 1;
    for (int c = 0; c < 6; c++) cyc();
    MulDivE = 0;
    for (int c = 0; c < 3; c++) cyc();

    // Reset during busy clears sticky error and drops stalls
    MulDivE = 1;
    for (int c = 0; c < 3; c++) cyc();
    rst = 1; cyc();
    rst = 0; MulDivE = 0; cyc();
    cyc();

    // Branch and mul/div together: branch wins
    MulDivE = 1; PCSrcE = 1; cyc();
    idle_inputs(); cyc();

    // Random traffic with small register space to provoke matches
    for (int i = 0; i < 1500; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 7) == 0);
      MulDivE    = ($urandom_range(0, 3) == 0);
      MdDone     = ($urandom_range(0, 4) == 0);
      rst        = ($urandom_range(0, 60) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
